dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences data-memory accesses for the instruction held in the EX/MEM pipeline register.
//  Decodes the stage's read_write field and drives a req/ack memory port (byte lanes, wdata replication).
//  Generates the busywait that freezes EX/MEM and the earlier pipeline registers.
//  Returns right-aligned, zero-extended load data to the MEM/WB path.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max REQ cycles without mem_ack before abort (used only with DMEM_TIMEOUT_EN)
// PORTS
//  clk          in   1   sole clock, rising edge
//  reset        in   1   synchronous, active-high reset
//  read_write   in   4   from EX/MEM: [3]=read, [2]=write, [1:0]=size (00 B, 01 H, 10 W, 11 illegal)
//  addr         in   32  byte address (EX/MEM alu_result)
//  wdata        in   32  store data (EX/MEM D_in)
//  busywait     out  1   stall to the pipeline registers
//  load_data    out  32  loaded value, right-aligned, zero-extended
//  access_err   out  1   1-cycle pulse: illegal or misaligned access
//  bus_err      out  1   1-cycle pulse: access aborted by timeout
//  mem_req      out  1   memory request, held until mem_ack
//  mem_we       out  1   1 = write
//  mem_addr     out  32  {addr[31:2],2'b00}
//  mem_be       out  4   byte enables
//  mem_wdata    out  32  lane-replicated store data
//  mem_rdata    in   32  read word, valid with mem_ack
//  mem_ack      in   1   1-cycle completion pulse
// BEHAVIOUR
//  - States: IDLE, REQ, DONE. Reset -> IDLE.
//  - Reset values: all outputs 0, including load_data and mem_* registers.
//  - access = read_write[3]^read_write[2] (exactly one set).
//  - illegal = both set, size==11, H with addr[0]!=0, or W with addr[1:0]!=0.
//  - IDLE, access & !illegal: busywait=1 combinationally in the same cycle.
//    Register mem_addr/mem_we/mem_be/mem_wdata and the byte offset/size; next state REQ.
//  - IDLE, access & illegal: no request, busywait=0; access_err pulses next cycle; stay IDLE.
//  - IDLE with read_write[3:2]==00: no action.
//  - REQ: mem_req=1, busywait=1; mem_* held stable.
//    On mem_ack: if read, load_data <= (mem_rdata >> 8*off), masked to B/H/W; next state DONE.
//    Writes leave load_data unchanged.
//  - DONE: mem_req=0, busywait=0 (pipeline advances this edge); next state IDLE, unconditionally.
//    An access newly presented in IDLE afterwards is then decoded.
//  - Minimum access: busywait high 2 cycles (IDLE detect + REQ with immediate ack).
//  - Byte enables: B -> 4'b0001<<off; H -> 4'b0011<<off; W -> 4'b1111.
//  - Store data: B -> {4{wdata[7:0]}}; H -> {2{wdata[15:0]}}; W -> wdata.
//  - mem_ack outside REQ is ignored.
//  - load_data holds its value until the next completed read.
//  - Reset mid-REQ: back to IDLE next edge, mem_req=0 and busywait=0; no error pulse.
// CONFIGURATION
//  DMEM_TIMEOUT_EN defined:
//    counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to REQ and increments each REQ cycle.
//    Count reaching TIMEOUT_CYCLES without ack: drop mem_req, pulse bus_err, load_data <= 0 (reads), go DONE.
//  DMEM_TIMEOUT_EN undefined:
//    no counter; REQ waits indefinitely; bus_err tied 0.
// TESTING
//  1. LW addr 0x100, ack 3 cycles after req, rdata 0xDEADBEEF -> busywait 4 cycles, mem_be=F, load_data=0xDEADBEEF.
//  2. SB addr 0x203, wdata 0x000000A5 -> mem_addr 0x200, mem_be=4'b1000, mem_wdata 0xA5A5A5A5, mem_we=1.
//  3. LH addr 0x101, or read_write=4'b1100 -> no mem_req, busywait=0, access_err 1-cycle pulse.
//  4. LB addr 0x302, ack with rdata 0x11223344 -> load_data=0x00000022.
//  5. Reset asserted during REQ -> next cycle state IDLE, mem_req=0, busywait=0; late ack ignored.
//  6. DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives -> bus_err pulse; busywait falls in DONE; load_data=0.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM stage: decode, req/ack port, busywait, load alignment.
// Optional request timeout enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  read_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busywait,
    output logic [31:0] load_data,
    output logic        access_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [1:0]  size;
    logic [1:0]  off;
    logic        access;
    logic        illegal;
    logic        start;
    logic        err_detect;
    logic        timeout;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        is_read_q;
    logic [31:0] shifted;
    logic [31:0] load_dec;

    assign size   = read_write[1:0];
    assign off    = addr[1:0];
    assign access = read_write[3] ^ read_write[2];

    always_comb begin
        illegal = 1'b0;
        if (read_write[3] && read_write[2])
            illegal = 1'b1;
        else if (size == 2'b11)
            illegal = 1'b1;
        else if (size == 2'b01 && addr[0])
            illegal = 1'b1;
        else if (size == 2'b10 && addr[1:0] != 2'b00)
            illegal = 1'b1;
    end

    always_comb begin
        be_dec    = 4'b1111;
        wdata_dec = wdata;
        case (size)
            2'b00: begin
                be_dec    = 4'b0001 << off;
                wdata_dec = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_dec    = 4'b0011 << off;
                wdata_dec = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted  = mem_rdata >> {off_q, 3'b000};
        load_dec = shifted;
        case (size_q)
            2'b00:   load_dec = {24'h0, shifted[7:0]};
            2'b01:   load_dec = {16'h0, shifted[15:0]};
            default: ;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] req_cnt;

    // Counter value is the number of REQ cycles already elapsed; abort on the last allowed one.
    always_ff @(posedge clk) begin
        if (reset || state != REQ)
            req_cnt <= '0;
        else
            req_cnt <= req_cnt + 1'b1;
    end

    assign timeout = (state == REQ) && !mem_ack && (req_cnt == TLAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        next_state = state;
        busywait   = 1'b0;
        mem_req    = 1'b0;
        start      = 1'b0;
        err_detect = 1'b0;
        case (state)
            IDLE: begin
                if ((read_write[3] || read_write[2]) && illegal) begin
                    err_detect = 1'b1;
                end else if (access) begin
                    start      = 1'b1;
                    busywait   = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                mem_req  = 1'b1;
                busywait = 1'b1;
                if (mem_ack || timeout)
                    next_state = DONE;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (reset) begin
            busywait   = 1'b0;
            mem_req    = 1'b0;
            start      = 1'b0;
            err_detect = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            load_data  <= '0;
            access_err <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            off_q      <= '0;
            size_q     <= '0;
            is_read_q  <= 1'b0;
        end else begin
            state      <= next_state;
            access_err <= err_detect;
            if (start) begin
                mem_we    <= read_write[2];
                mem_addr  <= {addr[31:2], 2'b00};
                mem_be    <= be_dec;
                mem_wdata <= wdata_dec;
                off_q     <= off;
                size_q    <= size;
                is_read_q <= read_write[3];
            end
            if (state == REQ && is_read_q) begin
                if (mem_ack)
                    load_data <= load_dec;
                else if (timeout)
                    load_data <= '0;
            end
        end
    end

`ifdef DMEM_TIMEOUT_EN
    logic bus_err_q;

    always_ff @(posedge clk) begin
        if (reset)
            bus_err_q <= 1'b0;
        else
            bus_err_q <= timeout;
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: expected port/load values queued at issue, checked at ack.
module tb_dmem_access_ctrl;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned TB_TO = 4;
`else
    localparam int unsigned TB_TO = 255;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  read_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busywait;
    logic [31:0] load_data;
    logic        access_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_load = '0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] load;
    } exp_t;

    exp_t sb[$];

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .reset(reset), .read_write(read_write), .addr(addr), .wdata(wdata),
        .busywait(busywait), .load_data(load_data), .access_err(access_err), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] rw, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rd,
                                   input logic [31:0] prev);
        exp_t e;
        int nb;
        int o;
        nb = (rw[1:0] == 2'b00) ? 1 : (rw[1:0] == 2'b01) ? 2 : 4;
        o  = int'(a[1:0]);
        e.addr  = a & 32'hFFFF_FFFC;
        e.we    = rw[2];
        e.be    = '0;
        e.wdata = '0;
        e.load  = '0;
        for (int i = 0; i < 4; i++) begin
            e.be[i] = (i >= o) && (i < o + nb);
            e.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        for (int i = 0; i < nb; i++)
            e.load[8*i +: 8] = rd[8*(o+i) +: 8];
        if (rw[2])
            e.load = prev;
        return e;
    endfunction

    // ack_after = REQ cycle on which the ack arrives (0 = never).
    task automatic run_access(input string name, input logic [3:0] rw, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int ack_after, input int exp_bw, input logic exp_berr);
        exp_t e;
        int bw_cycles;
        int req_cycles;
        bit ended;
        e = model(rw, a, wd, rd, last_load);
        if (exp_berr)
            e.load = rw[3] ? 32'h0 : last_load;
        sb.push_back(e);
        bw_cycles  = 0;
        req_cycles = 0;
        ended      = 1'b0;
        @(negedge clk);
        read_write = rw; addr = a; wdata = wd; mem_ack = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            #1;
            if (!busywait) begin
                ended = 1'b1;
                break;
            end
            bw_cycles++;
            if (mem_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    e = sb.pop_front();
                    checks++;
                    if (mem_addr !== e.addr || mem_be !== e.be || mem_wdata !== e.wdata || mem_we !== e.we) begin
                        failures++;
                        $display("FAIL %s port: addr=%h be=%b wdata=%h we=%b required addr=%h be=%b wdata=%h we=%b",
                                 name, mem_addr, mem_be, mem_wdata, mem_we, e.addr, e.be, e.wdata, e.we);
                    end
                end
                if (req_cycles == ack_after) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = $urandom;
        end
        checks++;
        if (!ended || bw_cycles != exp_bw) begin
            failures++;
            $display("FAIL %s busywait: cycles=%0d ended=%0d required=%0d", name, bw_cycles, ended, exp_bw);
        end
        checks++;
        if (bus_err !== exp_berr || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL %s done: bus_err=%b mem_req=%b required bus_err=%b mem_req=0", name, bus_err, mem_req, exp_berr);
        end
        checks++;
        if (load_data !== e.load) begin
            failures++;
            $display("FAIL %s load_data: got %h required %h", name, load_data, e.load);
        end
        last_load  = e.load;
        read_write = 4'b0000;
        @(negedge clk);
        #1;
        checks++;
        if (busywait !== 1'b0 || mem_req !== 1'b0 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: busywait=%b mem_req=%b bus_err=%b required 0", name, busywait, mem_req, bus_err);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; read_write = 4'b1010; addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({busywait, access_err, bus_err, mem_req, mem_we} !== 5'b0 ||
            load_data !== '0 || mem_addr !== '0 || mem_be !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset: bw=%b ae=%b be=%b req=%b we=%b ld=%h ma=%h mbe=%b mwd=%h required all 0",
                     busywait, access_err, bus_err, mem_req, mem_we, load_data, mem_addr, mem_be, mem_wdata);
        end
        read_write = 4'b0000;
        reset = 1'b0;
        last_load = '0;
    endtask

    task automatic test_load_word();
        run_access("lw_0x100", 4'b1010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 4, 1'b0);
        run_access("lw_fast", 4'b1010, 32'h1FC, 32'h0, 32'h01234567, 1, 2, 1'b0);
    endtask

    task automatic test_store();
        run_access("sb_0x203", 4'b0100, 32'h203, 32'h000000A5, 32'hFFFFFFFF, 1, 2, 1'b0);
        run_access("sh_0x202", 4'b0101, 32'h202, 32'h1234BEEF, 32'hFFFFFFFF, 2, 3, 1'b0);
        run_access("sw_0x40", 4'b0110, 32'h40, 32'hCAFEF00D, 32'hFFFFFFFF, 1, 2, 1'b0);
    endtask

    task automatic test_load_narrow();
        run_access("lb_0x302", 4'b1000, 32'h302, 32'h0, 32'h11223344, 1, 2, 1'b0);
        run_access("lb_0x303", 4'b1000, 32'h303, 32'h0, 32'h80223344, 2, 3, 1'b0);
        run_access("lh_0x302", 4'b1001, 32'h302, 32'h0, 32'h9ABC5678, 1, 2, 1'b0);
        run_access("lh_0x300", 4'b1001, 32'h300, 32'h0, 32'h9ABC5678, 1, 2, 1'b0);
    endtask

    task automatic test_illegal();
        logic [3:0]  rws[4]   = '{4'b1001, 4'b1100, 4'b1010, 4'b0111};
        logic [31:0] addrs[4] = '{32'h101, 32'h100, 32'h102, 32'h100};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            read_write = rws[i]; addr = addrs[i];
            #1;
            checks++;
            if (busywait !== 1'b0 || mem_req !== 1'b0 || access_err !== 1'b0) begin
                failures++;
                $display("FAIL illegal%0d detect: bw=%b req=%b ae=%b required 0 0 0", i, busywait, mem_req, access_err);
            end
            @(negedge clk);
            read_write = 4'b0000;
            #1;
            checks++;
            if (access_err !== 1'b1 || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL illegal%0d pulse: ae=%b req=%b required 1 0", i, access_err, mem_req);
            end
            @(negedge clk);
            #1;
            checks++;
            if (access_err !== 1'b0 || load_data !== last_load) begin
                failures++;
                $display("FAIL illegal%0d clear: ae=%b ld=%h required 0 %h", i, access_err, load_data, last_load);
            end
        end
    endtask

    task automatic test_ack_outside_req();
        @(negedge clk);
        read_write = 4'b0000; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if (load_data !== last_load || mem_req !== 1'b0 || busywait !== 1'b0) begin
            failures++;
            $display("FAIL stray_ack: ld=%h req=%b bw=%b required %h 0 0", load_data, mem_req, busywait, last_load);
        end
    endtask

    task automatic test_reset_mid_req();
        bit got_req;
        got_req = 1'b0;
        @(negedge clk);
        read_write = 4'b1010; addr = 32'h500;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (mem_req) begin
                got_req = 1'b1;
                break;
            end
        end
        checks++;
        if (!got_req) begin
            failures++;
            $display("FAIL rst_req enter: mem_req=%b required 1", mem_req);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        read_write = 4'b0000;
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busywait !== 1'b0 || access_err !== 1'b0 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_req after: req=%b bw=%b ae=%b be=%b required 0", mem_req, busywait, access_err, bus_err);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        last_load = '0;
        checks++;
        if (load_data !== 32'h0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_req late_ack: ld=%h req=%b required 0 0", load_data, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        run_access("b2b_lw", 4'b1010, 32'h600, 32'h0, 32'hA1B2C3D4, 1, 2, 1'b0);
        run_access("b2b_sb", 4'b0100, 32'h601, 32'h0000003C, 32'h0, 1, 2, 1'b0);
        run_access("b2b_lb", 4'b1000, 32'h601, 32'h0, 32'hA1B2C3D4, 2, 3, 1'b0);
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        run_access("timeout_rd", 4'b1010, 32'h700, 32'h0, 32'h0, 0, 1 + int'(TB_TO), 1'b1);
    endtask
`endif

    initial begin
        reset = 1'b0; read_write = '0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        test_reset();
        test_load_word();
        test_store();
        test_load_narrow();
        test_illegal();
        test_ack_outside_req();
        test_reset_mid_req();
        test_back_to_back();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
